lfsr_word_packer: RTL
=====================

Name: lfsr_word_packer

Overview:
- Downstream consumer of the 8-bit LFSR output stage.
- Samples LFSR bytes on qualified cycles and packs BYTES_PER_WORD consecutive bytes into one word, little-endian.
- Buffers completed words in a small first-word-fall-through FIFO behind a valid/ready interface, for the AXI read-side logic to drain.
- Counts words dropped because the FIFO was full.

Parameters:
- BYTE_W, 8: width of the LFSR output byte.
- BYTES_PER_WORD, 4: bytes packed per output word; power of 2, minimum 2.
- FIFO_DEPTH, 4: number of word entries; power of 2, minimum 2.
- OVF_W, 16: width of the saturating overflow counter.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- lfsr_out, input, BYTE_W: current LFSR state byte.
- sample_en, input, 1: high for each cycle in which lfsr_out holds a new value to be captured.
- flush, input, 1: synchronous clear of the pack accumulator and the FIFO.
- word_data, output, BYTE_W*BYTES_PER_WORD: FIFO head word.
- word_valid, output, 1: FIFO not empty.
- word_ready, input, 1: consumer accepts the head word.
- fifo_level, output, clog2(FIFO_DEPTH)+1: number of stored words, 0..FIFO_DEPTH.
- byte_idx, output, clog2(BYTES_PER_WORD): next byte lane to fill.
- overflow_cnt, output, OVF_W: number of dropped words, saturating.

Behaviour:
- Reset (sync, highest priority) clears every output and all state: word_data=0, word_valid=0, fifo_level=0, byte_idx=0, overflow_cnt=0, accumulator=0, read/write pointers=0.
- Packing:
  - On an edge with sample_en=1, lfsr_out is written into lane byte_idx, i.e. bits [byte_idx*BYTE_W +: BYTE_W], and byte_idx increments modulo BYTES_PER_WORD.
  - The first captured byte lands in the LSBs.
  - With sample_en=0, the accumulator and byte_idx hold; gaps between samples are allowed and of any length.
- Word completion:
  - Occurs on the edge where sample_en=1 and byte_idx=BYTES_PER_WORD-1.
  - The completed word (the 3 stored lanes plus the current lfsr_out) is pushed into the FIFO on that same edge.
  - word_valid rises in the following cycle if the FIFO was empty. Latency from the final byte's sampling edge to word_valid is 1 cycle.
- Pop: an edge with word_valid=1 and word_ready=1 removes the head. word_ready while word_valid=0 has no effect.
- Push/pop accounting on one edge:
  - Push only: level+1.
  - Pop only: level-1.
  - Both: level unchanged, and the push is accepted even when level=FIFO_DEPTH.
- Full:
  - A push with level=FIFO_DEPTH and no simultaneous pop drops the new word; FIFO contents are unchanged.
  - overflow_cnt increments by 1 and saturates at all-ones.
  - The accumulator still restarts at lane 0.
- Empty: word_valid=0 and word_data=0.
- word_data/word_valid are registered/FIFO-head driven; there is no combinational path from word_ready to word_valid.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is derived from an explicit count, so full and empty are unambiguous.
- flush:
  - Beats sample_en and word_ready on the same edge.
  - Clears accumulator, byte_idx, pointers and level; word_valid=0 next cycle.
  - overflow_cnt is not cleared.
  - A word that would have completed on the flush edge is discarded and not counted.
- Reset or flush mid-word: the partial bytes are lost, and the next sample goes to lane 0.

Test Plan:
1. Basic pack: after reset, drive sample_en=1 for 4 consecutive cycles with lfsr_out=0x11, 0x22, 0x33, 0x44 and hold word_ready=0 -> 1 cycle after the 4th edge, word_valid=1, word_data=0x44332211, fifo_level=1, byte_idx=0.
2. Gapped sampling: the same 4 bytes with sample_en toggling 1,0,0,1,1,0,1 -> identical word 0x44332211. byte_idx holds across gaps, and no word appears before the 4th sample.
3. Overflow: word_ready=0, feed 5 full words W0..W4 -> fifo_level=4, overflow_cnt=1, the head is still W0. Drain with word_ready=1 -> W0, W1, W2, W3 in order, then word_valid=0 and fifo_level=0.
4. Push and pop when full: with fifo_level=4, complete W4 on the same edge as a pop of W0 -> fifo_level stays 4, overflow_cnt unchanged, drain order W1, W2, W3, W4.
5. Flush mid-word: sample 0xAA, 0xBB, assert flush for 1 cycle, then sample 0x01, 0x02, 0x03, 0x04 -> the only word is 0x04030201. A FIFO non-empty before the flush reads fifo_level=0 after it, and overflow_cnt is preserved.
6. Reset mid-operation: with 2 words queued and byte_idx=2, assert reset for 1 cycle -> all outputs 0 next cycle, including overflow_cnt. A subsequent 4-byte sequence yields exactly one correct word.

Source files
------------

// File: rtl/lfsr_word_packer.sv
// LFSR byte packer: gathers BYTES_PER_WORD sampled LFSR bytes into a
// little-endian word and queues completed words in a first-word-fall-through
// FIFO behind a valid/ready port. Words that arrive while the FIFO is full
// are dropped and counted in a saturating counter.

// One byte lane of the pack accumulator.
module lfsr_word_packer_lane #(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [BYTE_W-1:0] d,
  output logic [BYTE_W-1:0] q
);
  // Lane register: cleared by reset or flush, loaded when its lane is addressed.
  always_ff @(posedge clk) begin
    if (reset || clr) q <= '0;
    else if (we)      q <= d;
  end
endmodule

module lfsr_word_packer #(
  parameter int BYTE_W         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int OVF_W          = 16,
  localparam int WORD_W = BYTE_W * BYTES_PER_WORD,
  localparam int IDX_W  = $clog2(BYTES_PER_WORD),
  localparam int PTR_W  = $clog2(FIFO_DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] lfsr_out,
  input  logic              sample_en,
  input  logic              flush,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [IDX_W-1:0]  byte_idx,
  output logic [OVF_W-1:0]  overflow_cnt
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] acc;
  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] new_word;
  logic [BYTES_PER_WORD-1:0]             lane_we;
  logic [FIFO_DEPTH-1:0][WORD_W-1:0]     mem;
  logic [PTR_W-1:0]                      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]                      count;
  logic                                  complete, pop, push_ok, drop;

  // Lane array: lane g captures lfsr_out when byte_idx points at it.
  // The top lane of a completed word is taken straight from lfsr_out.
  for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_lane
    assign lane_we[g] = sample_en && !flush && (byte_idx == IDX_W'(g));
    lfsr_word_packer_lane #(.BYTE_W(BYTE_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .we    (lane_we[g]),
      .d     (lfsr_out),
      .q     (acc[g])
    );
    if (g == BYTES_PER_WORD - 1) begin : g_top
      assign new_word[g] = lfsr_out;
    end else begin : g_low
      assign new_word[g] = acc[g];
    end
  end

  // Handshake decode; flush overrides both sampling and popping.
  assign complete = sample_en && !flush && (byte_idx == LAST_IDX);
  assign pop      = word_valid && word_ready && !flush;
  assign push_ok  = complete && ((count != FULL_LVL) || pop);
  assign drop     = complete && (count == FULL_LVL) && !pop;

  // FIFO head drives the output directly; forced to zero while empty.
  assign word_valid = (count != '0);
  assign word_data  = word_valid ? mem[rd_ptr] : '0;
  assign fifo_level = count;

  // Byte index, FIFO storage/pointers/count and the drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      byte_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (sample_en) byte_idx <= byte_idx + 1'b1;
      if (push_ok) begin
        mem[wr_ptr] <= new_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + 1'b1;
    end
  end
endmodule
